// File: rtl/fpga_exit_led_reporter.sv
// Latches the first SoC exit event and reports it on a status LED: solid for pass,
// repeating N-blink bursts separated by a dark gap for fail. Also drives the clock heartbeat LED.
module fpga_exit_led_reporter #(
    parameter int TICK_DIV             = 12_500_000,
    parameter int GAP_TICKS            = 4,
    parameter int CODE_BITS            = 4,
    parameter int CLK_LED_COUNT_LENGTH = 27
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 exit_valid_i,
    input  logic [31:0]          exit_value_i,
    output logic                 heartbeat_o,
    output logic                 status_led_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [CODE_BITS-1:0] exit_code_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int BW = CODE_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS,
        S_FAIL_ON,
        S_FAIL_OFF,
        S_GAP
    } state_t;

    state_t                         state_q, state_d;
    logic [CLK_LED_COUNT_LENGTH-1:0] hb_q;
    logic [PW-1:0]                  presc_q, presc_d;
    logic [BW-1:0]                  blink_q, blink_d;
    logic [GW-1:0]                  gap_q, gap_d;
    logic                           done_q, pass_q;
    logic [CODE_BITS-1:0]           code_q;
    logic                           tick;
    logic                           latch;
    logic                           led;

    // A zero code field on a nonzero value means the full 2^CODE_BITS blinks.
    function automatic logic [BW-1:0] blink_count(input logic [CODE_BITS-1:0] code,
                                                  input logic nonzero);
        if (code == '0 && nonzero) begin
            return BW'(1) << CODE_BITS;
        end
        return {1'b0, code};
    endfunction

    assign tick  = (presc_q == PW'(TICK_DIV - 1));
    assign latch = (state_q == S_IDLE) && exit_valid_i;

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (latch || tick) begin
            presc_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        blink_d = blink_q;
        gap_d   = gap_q;
        led     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (exit_valid_i) begin
                    if (exit_value_i == 32'd0) begin
                        state_d = S_PASS;
                    end else begin
                        state_d = S_FAIL_ON;
                        blink_d = blink_count(exit_value_i[CODE_BITS-1:0], 1'b1);
                    end
                end
            end
            S_PASS: begin
                led = 1'b1;
            end
            S_FAIL_ON: begin
                led = 1'b1;
                if (tick) begin
                    if (blink_q > BW'(1)) begin
                        blink_d = blink_q - BW'(1);
                        state_d = S_FAIL_OFF;
                    end else begin
                        gap_d   = GW'(GAP_TICKS);
                        state_d = S_GAP;
                    end
                end
            end
            S_FAIL_OFF: begin
                if (tick) begin
                    state_d = S_FAIL_ON;
                end
            end
            S_GAP: begin
                if (tick) begin
                    gap_d = gap_q - GW'(1);
                    if (gap_q == GW'(1)) begin
                        state_d = S_FAIL_ON;
                        blink_d = blink_count(code_q, !pass_q);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            hb_q    <= '0;
            presc_q <= '0;
            blink_q <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            hb_q    <= hb_q + 1'b1;
            presc_q <= presc_d;
            blink_q <= blink_d;
            gap_q   <= gap_d;
            if (latch) begin
                done_q <= 1'b1;
                pass_q <= (exit_value_i == 32'd0);
                code_q <= exit_value_i[CODE_BITS-1:0];
            end
        end
    end

    assign heartbeat_o  = hb_q[CLK_LED_COUNT_LENGTH-1];
    assign status_led_o = led;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign exit_code_o  = code_q;

endmodule
